// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle for the multi-cycle ALU.
//   start, alu_op, a, b       : request side, driven by the master (pipeline control)
//   y, hi, zero, overflow,
//   div_by_zero, busy, done   : result/status side, driven by the slave (alu_mc)
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, a, b,
        input  y, hi, zero, overflow, div_by_zero, busy, done
    );

    modport slave (
        input  start, alu_op, a, b,
        output y, hi, zero, overflow, div_by_zero, busy, done
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle, width-parametrised ALU for the EX stage.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_mc_if slave port
//          start/alu_op/a/b sampled on an edge where busy = 0
//          y/hi hold the result (product low/high, quotient/remainder)
//          zero, overflow, div_by_zero flags; busy while iterating;
//          done pulses for one cycle when results are written
// Single-cycle ops complete one edge after start. multu/divu iterate one bit
// per clock for WIDTH clocks; divu by zero completes in one cycle.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_NOR   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor
    logic             is_div;

    logic [WIDTH-1:0] y_r, hi_r;
    logic             ovf_r, dbz_r, done_r;

    logic             single, launch, finish;

    // ------------------------------------------------------------------
    // Single-cycle result path
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        sum, diff;
    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        s_y, s_hi;
    logic                    s_ovf, s_dbz;

    always_comb begin
        a_s   = bus.a;
        b_s   = bus.b;
        sum   = bus.a + bus.b;
        diff  = bus.a - bus.b;
        shamt = bus.a[SHW-1:0];
        s_y   = '0;
        s_hi  = '0;
        s_ovf = 1'b0;
        s_dbz = 1'b0;
        unique case (bus.alu_op)
            OP_ADD: begin
                s_y   = sum;
                s_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                s_y   = diff;
                s_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLL:  s_y = bus.b << shamt;
            OP_OR:   s_y = bus.a | bus.b;
            OP_AND:  s_y = bus.a & bus.b;
            OP_SLTU: s_y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLT:  s_y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_XOR:  s_y = bus.a ^ bus.b;
            OP_SRL:  s_y = bus.b >> shamt;
            OP_SRA:  s_y = WIDTH'(b_s >>> shamt);
            OP_NOR:  s_y = ~(bus.a | bus.b);
            // Only reached on this path when the divisor is zero.
            OP_DIVU: begin
                s_y   = '1;
                s_hi  = bus.a;
                s_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_acc, step_mq;

    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (is_div) begin
            step_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_mq  = {mq[WIDTH-2:0], div_ge};
        end else begin
            // Carry out of the add drops into the top of acc; the bit shifted
            // out of acc lands in the top of mq as the next product bit.
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        single    = 1'b0;
        launch    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alu_op == OP_MULTU ||
                        (bus.alu_op == OP_DIVU && bus.b != '0)) begin
                        launch    = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        single    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == CNT_ONE) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            y_r    <= '0;
            hi_r   <= '0;
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (single) begin
                y_r    <= s_y;
                hi_r   <= s_hi;
                ovf_r  <= s_ovf;
                dbz_r  <= s_dbz;
                done_r <= 1'b1;
            end
            if (launch) begin
                acc    <= '0;
                mq     <= bus.a;
                opnd   <= bus.b;
                is_div <= (bus.alu_op == OP_DIVU);
                cnt    <= CNT_INIT;
            end
            if (state == BUSY) begin
                acc <= step_acc;
                mq  <= step_mq;
                cnt <= cnt - CNT_ONE;
                if (finish) begin
                    y_r    <= step_mq;
                    hi_r   <= step_acc;
                    ovf_r  <= 1'b0;
                    dbz_r  <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.y           = y_r;
    assign bus.hi          = hi_r;
    assign bus.zero        = (y_r == '0);
    assign bus.overflow    = ovf_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.busy        = (state == BUSY);
    assign bus.done        = done_r;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH = 32), directed cases
// followed by random operations against an arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ry, output logic [31:0] rhi,
                         output logic rovf, output logic rdbz, output int lat);
        longint sa, sb, r;
        longint unsigned ua, ub, p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(a % 32);
        ry = '0; rhi = '0; rovf = 1'b0; rdbz = 1'b0; lat = 1;
        case (op)
            4'd0: begin r = sa + sb; ry = a + b; rovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd1: begin r = sa - sb; ry = a - b; rovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd2: ry = b << sh;
            4'd3: ry = a | b;
            4'd4: ry = a & b;
            4'd5: ry = (ua < ub) ? 32'd1 : 32'd0;
            4'd6: ry = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: ry = a ^ b;
            4'd8: ry = b >> sh;
            4'd9: ry = 32'(sb >>> sh);
            4'd10: ry = ~(a | b);
            4'd11: begin p = ua * ub; ry = p[31:0]; rhi = p[63:32]; lat = W + 1; end
            4'd12: begin
                if (b == 0) begin ry = '1; rhi = a; rdbz = 1'b1; end
                else begin ry = a / b; rhi = a % b; lat = W + 1; end
            end
            default: ;
        endcase
    endtask

    // Issue one op and check everything at its completion. If inject > 0, a
    // stray start is presented in that cycle of the operation.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inject, input string tag);
        logic [31:0] ey, ehi;
        logic eovf, edbz;
        int lat, n, busy_cnt;
        model(op, a, b, ey, ehi, eovf, edbz, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        n = 1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        busy_cnt = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_cnt++;
            if (n == inject) begin bus.start = 1'b1; bus.alu_op = 4'd0; end
            else bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busycyc"}, 64'(busy_cnt), 64'(lat - 1));
        chk({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_y"}, {32'd0, bus.y}, {32'd0, ey});
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        chk({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, (ey == 0)});
        chk({tag, "_ovf"}, {63'd0, bus.overflow}, {63'd0, eovf});
        chk({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, edbz});
    endtask

    initial begin
        logic [31:0] ey, ehi, ra, rb;
        logic eovf, edbz;
        logic [3:0] op, ops [4];
        logic [31:0] as [4], bs [4];
        int lat, dones;

        bus.start = 1'b0; bus.alu_op = '0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        #12;
        chk("rst_y", {32'd0, bus.y}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_zero", {63'd0, bus.zero}, 64'd1);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Arithmetic and compare
        run(4'd0, 32'h7FFFFFFF, 32'd1, 0, "add_ovf");
        repeat (3) @(posedge clk);
        #1 chk("ovf_hold", {63'd0, bus.overflow}, 64'd1);
        run(4'd1, 32'd3, 32'd5, 0, "sub_neg");
        run(4'd6, 32'hFFFFFFFF, 32'd1, 0, "slt");
        run(4'd5, 32'hFFFFFFFF, 32'd1, 0, "sltu");

        // Shifts, including an amount with bits above the shift field
        run(4'd2, 32'd4, 32'h80000010, 0, "sll");
        run(4'd8, 32'd4, 32'h80000010, 0, "srl");
        run(4'd9, 32'd4, 32'h80000010, 0, "sra");
        run(4'd9, 32'd36, 32'h80000010, 0, "sra36");
        run(4'd2, 32'd36, 32'h80000010, 0, "sll36");

        // Multiply with a stray start mid-operation; divide; divide by zero
        run(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, "multu_max");
        run(4'd12, 32'd100, 32'd7, 0, "divu");
        run(4'd12, 32'd5, 32'd0, 0, "divu_zero");
        run(4'd14, 32'h1234, 32'h5678, 0, "op14");

        // Start presented in the done cycle of a multu is accepted
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 4'd11; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (W) @(posedge clk);
        #1 chk("m_done", {63'd0, bus.done}, 64'd1);
        chk("m_y", {32'd0, bus.y}, 64'd42);
        bus.start = 1'b1; bus.alu_op = 4'd7; bus.a = 32'hF0F0; bus.b = 32'h0FF0;
        @(posedge clk); #1 bus.start = 1'b0;
        chk("dc_done", {63'd0, bus.done}, 64'd1);
        chk("dc_y", {32'd0, bus.y}, 64'h0000FF00);

        // Back-to-back single-cycle ops: done stays high
        for (int i = 0; i < 4; i++) begin
            ops[i] = 4'($urandom_range(0, 10));
            as[i] = $urandom; bs[i] = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = ops[0]; bus.a = as[0]; bus.b = bs[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            model(ops[i], as[i], bs[i], ey, ehi, eovf, edbz, lat);
            if (i < 3) begin bus.alu_op = ops[i+1]; bus.a = as[i+1]; bus.b = bs[i+1]; end
            else bus.start = 1'b0;
            chk("b2b_done", {63'd0, bus.done}, 64'd1);
            chk("b2b_y", {32'd0, bus.y}, {32'd0, ey});
            chk("b2b_ovf", {63'd0, bus.overflow}, {63'd0, eovf});
        end

        // Asynchronous reset mid-cycle after a nonzero result
        run(4'd11, 32'h12345678, 32'h9ABCDEF0, 0, "multu_pre");
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_y", {32'd0, bus.y}, 64'd0);
        chk("arst_hi", {32'd0, bus.hi}, 64'd0);
        chk("arst_zero", {63'd0, bus.zero}, 64'd1);
        chk("arst_ovf", {63'd0, bus.overflow}, 64'd0);
        chk("arst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-divide: no done afterwards, next add works
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 4'd12; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rdiv_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("rdiv_no_done", 64'(dones), 64'd0);
        run(4'd0, 32'd2, 32'd2, 0, "add_after_rst");

        // Random operations
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if (op == 4'd12 && $urandom_range(0, 4) == 0) rb = '0;
            run(op, ra, rb, (op == 4'd11 || op == 4'd12) ? int'($urandom_range(1, 30)) : 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the MIPS datapath. It extends the single-cycle 3-bit-opcode ALU with:
- a 4-bit opcode;
- correct two's-complement signed compare, logical and arithmetic right shifts, and signed overflow detection;
- iterative unsigned multiply and divide with a start/done handshake.

It sits in the EX stage. The pipeline control stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: request; accepted on a rising edge when `busy` = 0.
- `alu_op` in 4: operation select, sampled with `start`.
- `a` in WIDTH: left operand, sampled with `start`.
- `b` in WIDTH: right operand, sampled with `start`.
- `y` out WIDTH: result (product low half / quotient).
- `hi` out WIDTH: product high half / remainder; 0 for other ops.
- `zero` out 1: `y` == 0.
- `overflow` out 1: signed overflow for add/sub; 0 otherwise.
- `div_by_zero` out 1: set when divu is issued with `b` == 0.
- `busy` out 1: an iterative operation is in progress.
- `done` out 1: one-cycle pulse, results valid.

## Operation
- Opcodes and results:
  - 0 add: `y` = a+b.
  - 1 sub: `y` = a−b (full width, no truncation).
  - 2 sll: `y` = b << a[SHW-1:0].
  - 3 or.
  - 4 and.
  - 5 sltu: unsigned a<b → 1/0.
  - 6 slt: signed a<b → 1/0.
  - 7 xor.
  - 8 srl: `y` = b >> a[SHW-1:0], logical.
  - 9 sra: arithmetic right shift of b by the same amount.
  - 10 nor.
  - 11 multu: {hi,y} = a*b, unsigned, 2·WIDTH bits.
  - 12 divu: `y` = a/b, `hi` = a%b, unsigned.
  - 13–15: `y` = 0, `hi` = 0, `done` still pulses.
- `overflow`:
  - add: operands have equal sign and the result sign differs.
  - sub: operands have different sign and the result sign differs from a.
- Divide by zero: `y` = all ones, `hi` = a, `div_by_zero` = 1, no iteration, single-cycle latency.
- Flag hold: `div_by_zero` and `overflow` hold with the result and are recomputed on every accepted start.
- State machine, two states:
  - IDLE:
    - accepted start with opcode ≠ 11/12, or divu with b = 0 → compute, register outputs, pulse `done`, stay IDLE.
    - multu, or divu with b ≠ 0 → latch operands, clear accumulator, counter = WIDTH, go to BUSY.
  - BUSY:
    - One iteration per clock.
    - multu: shift-add, one multiplier bit per cycle, LSB first.
    - divu: restoring, one quotient bit per cycle, MSB first.
    - Counter decrements each cycle; at 1 → write `y`/`hi`, pulse `done`, return to IDLE.
- `start` while `busy`: ignored; no queuing; operands are not re-sampled.
- Output hold: `y`, `hi` and flags hold their last value until the next completion. They do not change during BUSY.
- `zero` is combinational from registered `y`.

## Timing
- Reset (asynchronous, immediate): `y` = 0, `hi` = 0, `zero` = 1, `overflow` = 0, `div_by_zero` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0.
- Reset mid-operation: iteration aborted; no `done`; first start after deassertion is accepted normally.
- Single-cycle ops: start sampled at edge E0 → outputs valid and `done` = 1 in the cycle after E0, for exactly one cycle. Back-to-back starts every cycle are allowed; `done` stays high continuously.
- multu/divu:
  - `busy` rises after E0 and falls after edge E_WIDTH.
  - Results are written and `done` = 1 in the cycle after E_WIDTH, i.e. WIDTH+1 edges from start to `done`.
  - `busy` and `done` are never both 1.
  - A start presented in the `done` cycle is accepted.
- Inputs need to be stable only at the accepting edge.

## Test plan
- Reset defaults: assert `rst` asynchronously mid-cycle → all outputs reach reset values before the next edge; `zero` = 1.
- Arithmetic and compare: add 0x7FFFFFFF+1 → `y` = 0x80000000, `overflow` = 1. sub 3−5 → `y` = 0xFFFFFFFE (no truncation), `overflow` = 0. slt(−1, 1) → 1. sltu(0xFFFFFFFF, 1) → 0.
- Shifts: a = 4, b = 0x80000010.
  - sll → 0x00000100.
  - srl → 0x08000001.
  - sra → 0xF8000001.
  - a = 36 → shift by 4, same results.
- Multiply: multu 0xFFFFFFFF×0xFFFFFFFF → `hi` = 0xFFFFFFFE, `y` = 0x00000001. `done` occurs exactly 33 edges after start; `busy` is high for 32 cycles. A start issued mid-operation is ignored.
- Divide: divu 100/7 → `y` = 14, `hi` = 2, latency 33. divu 5/0 → `y` = 0xFFFFFFFF, `hi` = 5, `div_by_zero` = 1, `done` the next cycle.
- Reset mid-divide: assert `rst` at iteration 10 → no `done`. A following add 2+2 gives `y` = 4 in the next cycle.
